game_master_fsm: RTL and testbench



---
 rtl/game_pkg.sv | 16 +
 rtl/game_master_fsm_btn_rise_det.sv | 21 ++
 rtl/game_master_fsm.sv | 148 ++++++++++++++
 tb/tb_game_master_fsm.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-flow definitions: MSM_STATE encoding and width, decoded by the
// display and snake-control logic.
package game_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    WIN   = 3'd2,
    FAIL  = 3'd3,
    PAUSE = 3'd4,
    DYING = 3'd5
  } state_t;

endpackage

// File: rtl/game_master_fsm_btn_rise_det.sv
// Rising-edge detector for debounced buttons. The previous-value register
// resets to ones, so a button held through reset does not register a press.
module btn_rise_det #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);

  logic [W-1:0] btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= '1;
    else        btn_q <= btn;
  end

  always_comb rise = btn & ~btn_q;

endmodule

// File: rtl/game_master_fsm.sv
// Master game-flow controller: lives with timed respawn, pause/resume,
// frozen-while-paused play timer. Optional best-score register: GAME_HISCORE_EN.
module game_master_fsm
  import game_pkg::*;
#(
  parameter int unsigned          SCORE_W     = 8,
  parameter int unsigned          WIN_SCORE   = 64,
  parameter int unsigned          TIME_W      = 38,
  parameter logic [TIME_W-1:0]    TIMEOUT_CYC = 38'h1BF08EB000,
  parameter int unsigned          LIVES       = 3,
  parameter int unsigned          LIVES_W     = 2,
  parameter int unsigned          RESPAWN_CYC = 50000000,
  parameter int unsigned          RESPAWN_W   = 26
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 BINL,
  input  logic                 BINU,
  input  logic                 BIND,
  input  logic                 BINR,
  input  logic                 BPAUSE,
  input  logic                 Hit_wall_sig,
  input  logic                 Hit_body_sig,
  input  logic                 Hit_block_sig,
  input  logic [SCORE_W-1:0]   SCORE,
  output logic [STATE_W-1:0]   MSM_STATE,
  output logic [LIVES_W-1:0]   LIVES_LEFT,
  output logic                 RESPAWN,
  output logic [SCORE_W-1:0]   HISCORE
);

  localparam logic [TIME_W-1:0]    TIMEOUT_LAST = TIMEOUT_CYC - TIME_W'(1);
  localparam logic [RESPAWN_W-1:0] RESPAWN_LAST = RESPAWN_W'(RESPAWN_CYC - 1);
  localparam logic [LIVES_W-1:0]   LIVES_INIT   = LIVES_W'(LIVES);
  localparam logic [SCORE_W-1:0]   WIN_THRESH   = SCORE_W'(WIN_SCORE);

  state_t               state, state_nxt;
  logic [LIVES_W-1:0]   lives, lives_nxt;
  logic [TIME_W-1:0]    timer, timer_nxt;
  logic [RESPAWN_W-1:0] resp_cnt, resp_cnt_nxt;
  logic                 respawn_q, respawn_nxt;
  logic [4:0]           rise;
  logic                 dir_rise, pause_rise, hit, win;

  btn_rise_det #(.W(5)) u_rise (
    .clk   (CLK),
    .rst_n (RESET_N),
    .btn   ({BPAUSE, BINR, BIND, BINU, BINL}),
    .rise  (rise)
  );

  always_comb begin
    dir_rise   = |rise[3:0];
    pause_rise = rise[4];
    hit        = Hit_wall_sig | Hit_body_sig | Hit_block_sig;
    win        = SCORE >= WIN_THRESH;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      lives     <= LIVES_INIT;
      timer     <= '0;
      resp_cnt  <= '0;
      respawn_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      lives     <= lives_nxt;
      timer     <= timer_nxt;
      resp_cnt  <= resp_cnt_nxt;
      respawn_q <= respawn_nxt;
    end
  end

  // PLAY branch order encodes event priority: win > hit > timeout > pause.
  always_comb begin
    state_nxt    = state;
    lives_nxt    = lives;
    timer_nxt    = timer;
    resp_cnt_nxt = resp_cnt;
    respawn_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (dir_rise) begin
          state_nxt = PLAY;
          lives_nxt = LIVES_INIT;
          timer_nxt = '0;
        end
      end
      PLAY: begin
        if (win) begin
          state_nxt = WIN;
        end else if (hit && lives == LIVES_W'(1)) begin
          state_nxt = FAIL;
          lives_nxt = '0;
        end else if (hit) begin
          state_nxt    = DYING;
          lives_nxt    = lives - LIVES_W'(1);
          resp_cnt_nxt = '0;
        end else if (timer == TIMEOUT_LAST) begin
          state_nxt = FAIL;
        end else if (pause_rise) begin
          state_nxt = PAUSE;
        end else if (timer != '1) begin
          timer_nxt = timer + TIME_W'(1);
        end
      end
      PAUSE: begin
        if (pause_rise) state_nxt = PLAY;
      end
      DYING: begin
        if (resp_cnt == RESPAWN_LAST) begin
          state_nxt   = PLAY;
          respawn_nxt = 1'b1;
        end else begin
          resp_cnt_nxt = resp_cnt + RESPAWN_W'(1);
        end
      end
      WIN, FAIL: begin
        timer_nxt = '0;
        if (dir_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef GAME_HISCORE_EN
  logic [SCORE_W-1:0] hiscore;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) hiscore <= '0;
    else if (state == PLAY && (state_nxt == WIN || state_nxt == FAIL) && SCORE > hiscore)
      hiscore <= SCORE;
  end
`endif

  always_comb begin
    MSM_STATE  = state;
    LIVES_LEFT = lives;
    RESPAWN    = respawn_q;
`ifdef GAME_HISCORE_EN
    HISCORE    = hiscore;
`else
    HISCORE    = '0;
`endif
  end

endmodule

// File: tb/tb_game_master_fsm.sv
// Directed bench for game_master_fsm with short sim parameters
// (WIN_SCORE=4, TIMEOUT_CYC=100, LIVES=2, RESPAWN_CYC=8).
module tb_game_master_fsm;

  localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_WIN = 3'd2,
                         S_FAIL = 3'd3, S_PAUSE = 3'd4, S_DYING = 3'd5;
`ifdef GAME_HISCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       binl = 0, binu = 0, bind_b = 0, binr = 0, bpause = 0;
  logic       hit_wall = 0, hit_body = 0, hit_block = 0;
  logic [7:0] score = '0;
  logic [2:0] msm_state;
  logic [1:0] lives_left;
  logic       respawn;
  logic [7:0] hiscore;

  int total = 0;
  int bad   = 0;

  game_master_fsm #(
    .SCORE_W(8), .WIN_SCORE(4), .TIME_W(38), .TIMEOUT_CYC(38'd100),
    .LIVES(2), .LIVES_W(2), .RESPAWN_CYC(8), .RESPAWN_W(26)
  ) dut (
    .CLK(clk), .RESET_N(rst_n),
    .BINL(binl), .BINU(binu), .BIND(bind_b), .BINR(binr), .BPAUSE(bpause),
    .Hit_wall_sig(hit_wall), .Hit_body_sig(hit_body), .Hit_block_sig(hit_block),
    .SCORE(score),
    .MSM_STATE(msm_state), .LIVES_LEFT(lives_left), .RESPAWN(respawn), .HISCORE(hiscore)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // From WIN/FAIL: BINL press restarts to IDLE, BINR press starts play.
  task automatic restart(input string tag);
    binl = 1; tick(1);
    total++;
    if (msm_state !== S_IDLE) begin bad++; $display("FAIL %s_idle: state=%0d want=%0d", tag, msm_state, S_IDLE); end
    binl = 0; tick(1);
    binr = 1; tick(1);
    total++;
    if (msm_state !== S_PLAY || lives_left !== 2'd2) begin
      bad++; $display("FAIL %s_play: state=%0d lives=%0d want state=%0d lives=2", tag, msm_state, lives_left, S_PLAY);
    end
    binr = 0;
  endtask

  task automatic test_reset();
    binu = 1; rst_n = 0; tick(2); rst_n = 1;
    total++;
    if (msm_state !== S_IDLE || lives_left !== 2'd2 || respawn !== 1'b0 || hiscore !== 8'd0) begin
      bad++; $display("FAIL reset_vals: state=%0d lives=%0d resp=%0b hs=%0d want 0/2/0/0", msm_state, lives_left, respawn, hiscore);
    end
    tick(3);
    total++;
    if (msm_state !== S_IDLE) begin bad++; $display("FAIL reset_held_btn: state=%0d want=%0d", msm_state, S_IDLE); end
    binu = 0; tick(1);
    binu = 1; tick(1);
    total++;
    if (msm_state !== S_PLAY || lives_left !== 2'd2) begin
      bad++; $display("FAIL reset_start: state=%0d lives=%0d want %0d/2", msm_state, lives_left, S_PLAY);
    end
    binu = 0;
  endtask

  task automatic test_dying();
    hit_body = 1; tick(1); hit_body = 0;
    total++;
    if (msm_state !== S_DYING || lives_left !== 2'd1) begin
      bad++; $display("FAIL dying_enter: state=%0d lives=%0d want %0d/1", msm_state, lives_left, S_DYING);
    end
    for (int i = 1; i < 8; i++) begin
      tick(1);
      total++;
      if (msm_state !== S_DYING || respawn !== 1'b0) begin
        bad++; $display("FAIL dying_hold%0d: state=%0d resp=%0b want %0d/0", i, msm_state, respawn, S_DYING);
      end
    end
    tick(1);
    total++;
    if (msm_state !== S_PLAY || respawn !== 1'b1) begin
      bad++; $display("FAIL respawn_pulse: state=%0d resp=%0b want %0d/1", msm_state, respawn, S_PLAY);
    end
    tick(1);
    total++;
    if (msm_state !== S_PLAY || respawn !== 1'b0) begin
      bad++; $display("FAIL respawn_end: state=%0d resp=%0b want %0d/0", msm_state, respawn, S_PLAY);
    end
    hit_block = 1; tick(1); hit_block = 0;
    total++;
    if (msm_state !== S_FAIL || lives_left !== 2'd0) begin
      bad++; $display("FAIL last_life: state=%0d lives=%0d want %0d/0", msm_state, lives_left, S_FAIL);
    end
  endtask

  // Restart leaves the timer at 0: 40 increments, pause, resume, then 60 PLAY cycles to timeout.
  task automatic test_pause_timeout();
    restart("restart1");
    tick(40);
    bpause = 1; tick(1); bpause = 0;
    total++;
    if (msm_state !== S_PAUSE) begin bad++; $display("FAIL pause_enter: state=%0d want=%0d", msm_state, S_PAUSE); end
    hit_wall = 1; score = 8'd9; binu = 1; tick(1); hit_wall = 0; score = 8'd0; binu = 0;
    tick(29);
    total++;
    if (msm_state !== S_PAUSE) begin bad++; $display("FAIL pause_ignore: state=%0d want=%0d", msm_state, S_PAUSE); end
    bpause = 1; tick(1); bpause = 0;
    total++;
    if (msm_state !== S_PLAY) begin bad++; $display("FAIL resume: state=%0d want=%0d", msm_state, S_PLAY); end
    for (int i = 1; i < 60; i++) begin
      tick(1);
      total++;
      if (msm_state !== S_PLAY) begin bad++; $display("FAIL timer_run%0d: state=%0d want=%0d", i, msm_state, S_PLAY); end
    end
    tick(1);
    total++;
    if (msm_state !== S_FAIL || lives_left !== 2'd2) begin
      bad++; $display("FAIL timeout: state=%0d lives=%0d want %0d/2", msm_state, lives_left, S_FAIL);
    end
  endtask

  task automatic play_to_fail(input logic [7:0] sc, input string tag);
    restart(tag);
    score = sc;
    hit_wall = 1; tick(1); hit_wall = 0;
    tick(9);
    hit_body = 1; tick(1); hit_body = 0;
    total++;
    if (msm_state !== S_FAIL) begin bad++; $display("FAIL %s_end: state=%0d want=%0d", tag, msm_state, S_FAIL); end
  endtask

  task automatic test_hiscore();
    play_to_fail(8'd3, "hs_game1");
    total++;
    if (hiscore !== (HS_EN ? 8'd3 : 8'd0)) begin
      bad++; $display("FAIL hiscore1: got=%0d want=%0d", hiscore, HS_EN ? 3 : 0);
    end
    play_to_fail(8'd2, "hs_game2");
    score = 0;
    total++;
    if (hiscore !== (HS_EN ? 8'd3 : 8'd0)) begin
      bad++; $display("FAIL hiscore2: got=%0d want=%0d", hiscore, HS_EN ? 3 : 0);
    end
  endtask

  task automatic test_win_beats_hit();
    restart("win_restart");
    score = 8'd4; hit_wall = 1; tick(1); hit_wall = 0;
    total++;
    if (msm_state !== S_WIN || lives_left !== 2'd2) begin
      bad++; $display("FAIL win_vs_hit: state=%0d lives=%0d want %0d/2", msm_state, lives_left, S_WIN);
    end
    score = 0; tick(1);
    total++;
    if (hiscore !== (HS_EN ? 8'd4 : 8'd0)) begin
      bad++; $display("FAIL hiscore_win: got=%0d want=%0d", hiscore, HS_EN ? 4 : 0);
    end
  endtask

  task automatic test_async_reset();
    restart("ar_restart");
    hit_body = 1; tick(1); hit_body = 0;
    #2 rst_n = 0;
    #1;
    total++;
    if (msm_state !== S_IDLE || hiscore !== 8'd0 || lives_left !== 2'd2) begin
      bad++; $display("FAIL async_reset: state=%0d hs=%0d lives=%0d want 0/0/2", msm_state, hiscore, lives_left);
    end
    tick(1); rst_n = 1; tick(1);
    total++;
    if (msm_state !== S_IDLE) begin bad++; $display("FAIL post_reset: state=%0d want=%0d", msm_state, S_IDLE); end
  endtask

  initial begin
    test_reset();
    test_dying();
    test_pause_timeout();
    test_hiscore();
    test_win_beats_hit();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
